// File: rtl/saturn_bus_controller.sv
// saturn_bus_controller: CPU-side master of the Saturn nibble bus. It turns one fetch/read
//   request into a command nibble, an optional 5-nibble address load and len data strobes, and
//   it returns the nibbles the slaves drive back. It also keeps shadow copies of the slave PC/DP.
// Latency: CMD on the first bus tick after accept, then ADDR (5 ticks, load kinds only), then
//   DATA (len ticks). Each returned nibble appears one i_clk after its DATA tick.
// Backpressure: o_req_ready is high only in IDLE. Ticks with i_clk_en=0 or i_bus_clk_en=0 freeze
//   all state; a pending o_rd_valid pulse still completes.
// Ports: i_clk/i_reset (sync, active-high), i_clk_en/i_bus_clk_en (bus tick = both high),
//   bus pins i_bus_nibble_in/o_bus_is_data/o_bus_nibble_out, request i_req_*/o_req_ready,
//   read return o_rd_valid/o_rd_nibble/o_rd_last, status o_busy, o_pc_shadow, o_dp_shadow.
// Option: define SATURN_BUSCTL_AUTOLOAD_EN so that kinds 0/1 also use i_req_addr. A read whose
//   address differs from the matching shadow is then promoted to the LOAD variant.

`ifndef BUSCMD_PC_READ
`define BUSCMD_PC_READ 4'h0
`endif
`ifndef BUSCMD_DP_READ
`define BUSCMD_DP_READ 4'h1
`endif
`ifndef BUSCMD_LOAD_PC
`define BUSCMD_LOAD_PC 4'h4
`endif
`ifndef BUSCMD_LOAD_DP
`define BUSCMD_LOAD_DP 4'h5
`endif

module saturn_bus_controller (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clk_en,
    input  logic        i_bus_clk_en,
    input  logic [3:0]  i_bus_nibble_in,
    output logic        o_bus_is_data,
    output logic [3:0]  o_bus_nibble_out,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [1:0]  i_req_kind,
    input  logic [19:0] i_req_addr,
    input  logic [3:0]  i_req_len,
    output logic        o_rd_valid,
    output logic [3:0]  o_rd_nibble,
    output logic        o_rd_last,
    output logic        o_busy,
    output logic [19:0] o_pc_shadow,
    output logic [19:0] o_dp_shadow
);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_ADDR, S_DATA} state_t;

    state_t      state_q, state_d;
    logic [1:0]  kind_q, kind_d;       // bit1 = load variant, bit0 = DP pointer
    logic [19:0] addr_q, addr_d;
    logic [4:0]  len_q, len_d;         // remaining DATA ticks (1..16)
    logic [2:0]  idx_q, idx_d;         // address nibble index
    logic        use_dp_q, use_dp_d;   // selects the idle command
    logic [19:0] pc_q, pc_d, dp_q, dp_d;
    logic        pend_q, pend_d, pend_last_q, pend_last_d;
    logic        rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
    logic [3:0]  rd_nibble_q, rd_nibble_d;

    logic        tick, accept, promote;
    logic [3:0]  addr_nib;

    assign tick   = i_clk_en & i_bus_clk_en;
    assign accept = tick & (state_q == S_IDLE) & i_req_valid;

`ifdef SATURN_BUSCTL_AUTOLOAD_EN
    // A plain read is enough only when the slave pointer already holds the address.
    assign promote = ~i_req_kind[1] & (i_req_addr != (i_req_kind[0] ? dp_q : pc_q));
`else
    assign promote = 1'b0;
`endif

    always_comb begin
        case (idx_q)
            3'd0:    addr_nib = addr_q[3:0];
            3'd1:    addr_nib = addr_q[7:4];
            3'd2:    addr_nib = addr_q[11:8];
            3'd3:    addr_nib = addr_q[15:12];
            default: addr_nib = addr_q[19:16];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        addr_d      = addr_q;
        len_d       = len_q;
        idx_d       = idx_q;
        use_dp_d    = use_dp_q;
        pc_d        = pc_q;
        dp_d        = dp_q;
        pend_d      = 1'b0;
        pend_last_d = 1'b0;
        // The return path runs on every i_clk so a pending pulse completes even during a freeze.
        rd_valid_d  = pend_q;
        rd_last_d   = pend_last_q;
        rd_nibble_d = pend_q ? i_bus_nibble_in : rd_nibble_q;
        o_bus_is_data    = 1'b0;
        o_bus_nibble_out = use_dp_q ? `BUSCMD_DP_READ : `BUSCMD_PC_READ;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    kind_d   = {i_req_kind[1] | promote, i_req_kind[0]};
                    addr_d   = i_req_addr;
                    len_d    = (i_req_len == 4'd0) ? 5'd16 : {1'b0, i_req_len};
                    use_dp_d = i_req_kind[0];
                    state_d  = S_CMD;
                end
            end
            S_CMD: begin
                case (kind_q)
                    2'd0:    o_bus_nibble_out = `BUSCMD_PC_READ;
                    2'd1:    o_bus_nibble_out = `BUSCMD_DP_READ;
                    2'd2:    o_bus_nibble_out = `BUSCMD_LOAD_PC;
                    default: o_bus_nibble_out = `BUSCMD_LOAD_DP;
                endcase
                if (tick) begin
                    idx_d   = 3'd0;
                    state_d = kind_q[1] ? S_ADDR : S_DATA;
                end
            end
            S_ADDR: begin
                o_bus_is_data    = 1'b1;
                o_bus_nibble_out = addr_nib;
                if (tick) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd4) begin
                        if (kind_q[0]) dp_d = addr_q;
                        else           pc_d = addr_q;
                        state_d = S_DATA;
                    end
                end
            end
            default: begin // S_DATA
                o_bus_is_data    = 1'b1;
                o_bus_nibble_out = 4'h0;
                if (tick) begin
                    pend_d      = 1'b1;
                    pend_last_d = (len_q == 5'd1);
                    if (kind_q[0]) dp_d = dp_q + 20'd1;
                    else           pc_d = pc_q + 20'd1;
                    len_d = len_q - 5'd1;
                    if (len_q == 5'd1) state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            kind_q      <= 2'd0;
            addr_q      <= 20'h0;
            len_q       <= 5'd0;
            idx_q       <= 3'd0;
            use_dp_q    <= 1'b0;
            pc_q        <= 20'h0;
            dp_q        <= 20'h0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_nibble_q <= 4'h0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            use_dp_q    <= use_dp_d;
            pc_q        <= pc_d;
            dp_q        <= dp_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            rd_nibble_q <= rd_nibble_d;
        end
    end

    assign o_req_ready = (state_q == S_IDLE);
    assign o_busy      = (state_q != S_IDLE);
    assign o_rd_valid  = rd_valid_q;
    assign o_rd_nibble = rd_nibble_q;
    assign o_rd_last   = rd_last_q;
    assign o_pc_shadow = pc_q;
    assign o_dp_shadow = dp_q;

endmodule

// File: tb/tb_saturn_bus_controller.sv
// tb_saturn_bus_controller: directed bench for saturn_bus_controller. A small behavioural Saturn
//   slave (a ROM with PC/DP pointers) answers on the bus. Bus ticks and returned nibbles are
//   logged and then compared against hand-built expected sequences.

`ifndef BUSCMD_PC_READ
`define BUSCMD_PC_READ 4'h0
`endif
`ifndef BUSCMD_DP_READ
`define BUSCMD_DP_READ 4'h1
`endif
`ifndef BUSCMD_LOAD_PC
`define BUSCMD_LOAD_PC 4'h4
`endif
`ifndef BUSCMD_LOAD_DP
`define BUSCMD_LOAD_DP 4'h5
`endif

module tb_saturn_bus_controller;

    logic        clk = 1'b0;
    logic        rst, clk_en, bus_clk_en;
    logic [3:0]  bus_in;
    logic        bus_is_data;
    logic [3:0]  bus_nib;
    logic        req_valid, req_ready;
    logic [1:0]  req_kind;
    logic [19:0] req_addr;
    logic [3:0]  req_len;
    logic        rd_valid, rd_last, busy;
    logic [3:0]  rd_nibble;
    logic [19:0] pc_shadow, dp_shadow;

    always #5 clk = ~clk;

    saturn_bus_controller dut (
        .i_clk(clk), .i_reset(rst), .i_clk_en(clk_en), .i_bus_clk_en(bus_clk_en),
        .i_bus_nibble_in(bus_in), .o_bus_is_data(bus_is_data), .o_bus_nibble_out(bus_nib),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_kind(req_kind),
        .i_req_addr(req_addr), .i_req_len(req_len), .o_rd_valid(rd_valid),
        .o_rd_nibble(rd_nibble), .o_rd_last(rd_last), .o_busy(busy),
        .o_pc_shadow(pc_shadow), .o_dp_shadow(dp_shadow)
    );

    function automatic logic [3:0] rom(input logic [19:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12] ^ a[19:16] ^ 4'h5;
    endfunction

    // Behavioural slave: latches commands, assembles load addresses, streams ROM nibbles.
    logic [19:0] s_pc, s_dp;
    logic [3:0]  s_cmd;
    logic [2:0]  s_idx;
    always @(posedge clk) begin
        if (rst) begin
            s_pc <= 20'h0; s_dp <= 20'h0; s_cmd <= `BUSCMD_PC_READ; s_idx <= 3'd0; bus_in <= 4'h0;
        end else if (clk_en && bus_clk_en) begin
            if (!bus_is_data) begin
                s_cmd <= bus_nib;
                s_idx <= 3'd0;
            end else if (s_cmd == `BUSCMD_LOAD_PC || s_cmd == `BUSCMD_LOAD_DP) begin
                if (s_cmd == `BUSCMD_LOAD_PC) s_pc[int'(s_idx)*4 +: 4] <= bus_nib;
                else                          s_dp[int'(s_idx)*4 +: 4] <= bus_nib;
                s_idx <= s_idx + 3'd1;
                if (s_idx == 3'd4)
                    s_cmd <= (s_cmd == `BUSCMD_LOAD_PC) ? `BUSCMD_PC_READ : `BUSCMD_DP_READ;
            end else if (s_cmd == `BUSCMD_PC_READ) begin
                bus_in <= rom(s_pc);
                s_pc   <= s_pc + 20'd1;
            end else if (s_cmd == `BUSCMD_DP_READ) begin
                bus_in <= rom(s_dp);
                s_dp   <= s_dp + 20'd1;
            end
        end
    end

    logic [4:0] bus_log[$], bus_exp[$], rd_log[$], rd_exp[$];

    always @(negedge clk) begin
        if (clk_en && bus_clk_en && busy) bus_log.push_back({bus_is_data, bus_nib});
        if (rd_valid) rd_log.push_back({rd_last, rd_nibble});
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic exp_cmd(input logic [3:0] c);
        bus_exp.push_back({1'b0, c});
    endtask

    task automatic exp_addr(input logic [19:0] a);
        for (int i = 0; i < 5; i++) bus_exp.push_back({1'b1, a[4*i +: 4]});
    endtask

    task automatic exp_data(input logic [19:0] a, input int n);
        for (int i = 0; i < n; i++) begin
            bus_exp.push_back({1'b1, 4'h0});
            rd_exp.push_back({(i == n - 1), rom(a + 20'(i))});
        end
    endtask

    task automatic check_logs(input string tag);
        check_vec({tag, "_bus_len"}, bus_log.size(), bus_exp.size());
        for (int i = 0; i < bus_log.size() && i < bus_exp.size(); i++)
            check_vec($sformatf("%s_bus%0d", tag, i), bus_log[i], bus_exp[i]);
        check_vec({tag, "_rd_len"}, rd_log.size(), rd_exp.size());
        for (int i = 0; i < rd_log.size() && i < rd_exp.size(); i++)
            check_vec($sformatf("%s_rd%0d", tag, i), rd_log[i], rd_exp[i]);
        bus_log.delete(); bus_exp.delete(); rd_log.delete(); rd_exp.delete();
    endtask

    // Entered and left at posedge+2.
    task automatic start_req(input logic [1:0] k, input logic [19:0] a, input logic [3:0] l);
        req_kind = k; req_addr = a; req_len = l; req_valid = 1'b1;
        @(posedge clk); #2;
        req_valid = 1'b0; req_addr = 20'h0; req_len = 4'h0; req_kind = 2'd0;
        check_vec("ready_after_accept", req_ready, 0);
        check_vec("busy_after_accept", busy, 1);
    endtask

    task automatic wait_done();
        bit done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk); #2;
            if (!busy) done = 1;
        end
        check_vec("done_in_budget", busy, 0);
        repeat (3) @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clk_en = 1'b1; bus_clk_en = 1'b1;
        req_valid = 1'b0; req_kind = 2'd0; req_addr = 20'h0; req_len = 4'h0;
        repeat (3) @(posedge clk);
        #2;
        check_vec("rst_is_data", bus_is_data, 0);
        check_vec("rst_nibble", bus_nib, `BUSCMD_PC_READ);
        check_vec("rst_ready", req_ready, 1);
        check_vec("rst_busy", busy, 0);
        check_vec("rst_rd_valid", rd_valid, 0);
        check_vec("rst_rd_nibble", rd_nibble, 0);
        check_vec("rst_rd_last", rd_last, 0);
        check_vec("rst_pc", pc_shadow, 20'h0);
        check_vec("rst_dp", dp_shadow, 20'h0);
        rst = 1'b0;
        @(posedge clk); #2;

        // Reset during the third address tick.
        start_req(2'd2, 20'hABCDE, 4'd2);
        repeat (3) @(posedge clk);
        #2;
        check_vec("addr3_is_data", bus_is_data, 1);
        check_vec("addr3_nibble", bus_nib, 4'hC);
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        check_vec("midrst_is_data", bus_is_data, 0);
        check_vec("midrst_nibble", bus_nib, `BUSCMD_PC_READ);
        check_vec("midrst_busy", busy, 0);
        check_vec("midrst_pc", pc_shadow, 20'h0);
        repeat (6) @(posedge clk);
        #2;
        check_vec("midrst_no_rd", rd_log.size(), 0);
        bus_log.delete(); rd_log.delete();

        // Load PC 12345, two nibbles.
        start_req(2'd2, 20'h12345, 4'd2);
        wait_done();
        exp_cmd(`BUSCMD_LOAD_PC); exp_addr(20'h12345); exp_data(20'h12345, 2);
        check_logs("ldpc");
        check_vec("ldpc_pc", pc_shadow, 20'h12347);

        // Plain PC read, len 0 means 16.
        start_req(2'd0, 20'h0, 4'd0);
        wait_done();
        exp_cmd(`BUSCMD_PC_READ); exp_data(20'h12347, 16);
        check_logs("pc16");
        check_vec("pc16_pc", pc_shadow, 20'h12357);

        // Load DP across the 20-bit wrap.
        start_req(2'd3, 20'hFFFFE, 4'd3);
        wait_done();
        exp_cmd(`BUSCMD_LOAD_DP); exp_addr(20'hFFFFE); exp_data(20'hFFFFE, 3);
        check_logs("lddp");
        check_vec("lddp_dp", dp_shadow, 20'h00001);
        check_vec("lddp_pc_kept", pc_shadow, 20'h12357);
        check_vec("idle_dp_is_data", bus_is_data, 0);
        check_vec("idle_dp_cmd", bus_nib, `BUSCMD_DP_READ);

        // Bus strobe frozen for 4 cycles after two DATA ticks.
        start_req(2'd1, 20'h0, 4'd6);
        repeat (3) @(posedge clk);
        #2;
        bus_clk_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_vec($sformatf("frz%0d_busy", i), busy, 1);
            check_vec($sformatf("frz%0d_is_data", i), bus_is_data, 1);
            check_vec($sformatf("frz%0d_nibble", i), bus_nib, 4'h0);
            check_vec($sformatf("frz%0d_dp", i), dp_shadow, 20'h00003);
        end
        @(posedge clk); #2;
        bus_clk_en = 1'b1;
        wait_done();
        exp_cmd(`BUSCMD_DP_READ); exp_data(20'h00001, 6);
        check_logs("frz");
        check_vec("frz_dp", dp_shadow, 20'h00007);

        // Read at the current shadow: never needs a load.
        start_req(2'd0, 20'h12357, 4'd1);
        wait_done();
        exp_cmd(`BUSCMD_PC_READ); exp_data(20'h12357, 1);
        check_logs("al_same");
        check_vec("al_same_pc", pc_shadow, 20'h12358);

        // Read at shadow+8.
        start_req(2'd0, 20'h12360, 4'd1);
        wait_done();
`ifdef SATURN_BUSCTL_AUTOLOAD_EN
        exp_cmd(`BUSCMD_LOAD_PC); exp_addr(20'h12360); exp_data(20'h12360, 1);
        check_logs("al_diff");
        check_vec("al_diff_pc", pc_shadow, 20'h12361);
`else
        exp_cmd(`BUSCMD_PC_READ); exp_data(20'h12358, 1);
        check_logs("al_diff");
        check_vec("al_diff_pc", pc_shadow, 20'h12359);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
